jt10_adpcma_rombridge: RTL and testbench

JT10_ADPCMA_ROMBRIDGE -- requirements
Module: jt10_adpcma_rombridge

---
 rtl/jt10_adpcma_rombridge.sv | 133 +++++++++++++
 tb/tb_jt10_adpcma_rombridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcma_rombridge.sv
// ADPCM-A ROM bridge: turns the byte-wide ADPCM-A ROM port into word-wide
// external memory reads. A one-entry word cache returns the second byte of a
// word without another external access.
module jt10_adpcma_rombridge (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic [19:0] addr,
   input  logic [3:0]  bank,
   input  logic        roe_n,
   input  logic        flush,
   input  logic        clr_ovr,
   output logic [7:0]  datain,
   output logic [22:0] rom_addr,
   output logic        rom_cs,
   input  logic        rom_ok,
   input  logic [15:0] rom_data,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t      state, nxt_state;
   logic        roe_q;
   logic        bsel_q;
   logic [22:0] tag;
   logic [15:0] cdata;
   logic        valid;

   logic [23:0] a24;
   logic [22:0] word;
   logic        bsel_now;
   logic        req;
   logic        hit;
   logic        do_hit, do_issue, do_fill, set_ovr;

   // cen only keeps this block aligned with the driver pipeline
   logic unused_cen;
   assign unused_cen = cen;

   assign a24      = {bank, addr};
   assign word     = a24[23:1];
   assign bsel_now = a24[0];
   assign req      = roe_q & ~roe_n;
   // A request that coincides with flush must miss
   assign hit      = valid & (tag == word) & ~flush;
   // The external request is high for the whole ISSUE/WAIT span and drops
   // with the asynchronous reset of the state register
   assign rom_cs   = (state != IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   // Next-state decode and one-cycle action strobes
   always_comb begin
      nxt_state = state;
      do_hit    = 1'b0;
      do_issue  = 1'b0;
      do_fill   = 1'b0;
      set_ovr   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  do_hit = 1'b1;
               end else begin
                  do_issue  = 1'b1;
                  nxt_state = ISSUE;
               end
            end
         end
         ISSUE: begin
            // rom_ok here may be left over from the previous access
            if (req) begin
               do_issue  = 1'b1;
               set_ovr   = 1'b1;
               nxt_state = ISSUE;
            end else begin
               nxt_state = WAIT;
            end
         end
         WAIT: begin
            // A new request supersedes the pending one, even if ok arrives now
            if (req) begin
               do_issue  = 1'b1;
               set_ovr   = 1'b1;
               nxt_state = ISSUE;
            end else if (rom_ok) begin
               do_fill   = 1'b1;
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Address latch, cache contents, returned byte and overrun flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         roe_q    <= 1'b1;
         bsel_q   <= 1'b0;
         rom_addr <= 23'd0;
         datain   <= 8'd0;
         tag      <= 23'd0;
         cdata    <= 16'd0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         roe_q <= roe_n;
         if (do_issue) begin
            rom_addr <= word;
            bsel_q   <= bsel_now;
         end
         if (do_hit)
            datain <= bsel_now ? cdata[15:8] : cdata[7:0];
         if (do_fill) begin
            datain <= bsel_q ? rom_data[15:8] : rom_data[7:0];
            tag    <= rom_addr;
            cdata  <= rom_data;
         end
         // flush wins over a fill finishing on the same clock
         if (flush)        valid <= 1'b0;
         else if (do_fill) valid <= 1'b1;
         // a new overrun wins over a simultaneous clear
         if (set_ovr)      overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jt10_adpcma_rombridge.sv
// Scoreboard bench for jt10_adpcma_rombridge: directed stimulus pushes
// expectations stamped with the cycle they are due; a negedge monitor
// compares every due entry against the DUT outputs.
module tb_jt10_adpcma_rombridge;

   logic        rst, clk, cen;
   logic [19:0] addr;
   logic [3:0]  bank;
   logic        roe_n, flush, clr_ovr;
   logic [7:0]  datain;
   logic [22:0] rom_addr;
   logic        rom_cs;
   logic        rom_ok;
   logic [15:0] rom_data;
   logic        overrun;

   jt10_adpcma_rombridge dut (
      .rst(rst), .clk(clk), .cen(cen), .addr(addr), .bank(bank),
      .roe_n(roe_n), .flush(flush), .clr_ovr(clr_ovr), .datain(datain),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok),
      .rom_data(rom_data), .overrun(overrun)
   );

   localparam int K_CS = 0, K_ADDR = 1, K_DATA = 2, K_OVR = 3, K_NCS = 4;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   applied = 0;
   int   errors = 0;
   int   ncs = 0;
   logic cs_prev = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: count rom_cs pulses and compare every due expectation
   always @(negedge clk) begin
      if (rom_cs && !cs_prev) ncs++;
      cs_prev = rom_cs;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            logic [31:0] act;
            case (sb[i].kind)
               K_CS:    act = {31'd0, rom_cs};
               K_ADDR:  act = {9'd0, rom_addr};
               K_DATA:  act = {24'd0, datain};
               K_OVR:   act = {31'd0, overrun};
               default: act = ncs;
            endcase
            applied++;
            if (act !== sb[i].val) begin
               errors++;
               $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
                        sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int dly, input int kind, input logic [31:0] val,
                            input string name);
      exp_t e;
      e.cyc = cyc + dly; e.kind = kind; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   initial begin
      rst = 1'b1; cen = 1'b1; addr = '0; bank = '0; roe_n = 1'b1;
      flush = 1'b0; clr_ovr = 1'b0; rom_ok = 1'b0; rom_data = '0;
      tick(3);
      // Reset state
      expect_at(0, K_CS, 0, "rst_cs");
      expect_at(0, K_DATA, 0, "rst_datain");
      expect_at(0, K_ADDR, 0, "rst_romaddr");
      expect_at(0, K_OVR, 0, "rst_overrun");
      tick(1);
      rst = 1'b0;
      tick(2);

      // Cold miss: A24=0x100235 -> word 0x08011A, high byte
      bank = 4'h1; addr = 20'h00235; roe_n = 1'b0;
      expect_at(1, K_CS, 1, "cold_cs_rise");
      expect_at(1, K_ADDR, 32'h08011A, "cold_romaddr");
      tick(3);
      expect_at(0, K_DATA, 0, "cold_no_early_data");
      rom_ok = 1'b1; rom_data = 16'hBEEF;
      expect_at(1, K_DATA, 32'hBE, "cold_datain");
      expect_at(1, K_CS, 0, "cold_cs_fall");
      expect_at(1, K_NCS, 1, "cold_one_pulse");
      tick(1);
      rom_ok = 1'b0; roe_n = 1'b1;
      tick(1);

      // Hit on low byte of the cached word
      addr = 20'h00234; roe_n = 1'b0;
      expect_at(1, K_DATA, 32'hEF, "hit_datain");
      expect_at(1, K_CS, 0, "hit_no_cs");
      tick(1);
      roe_n = 1'b1;
      expect_at(1, K_NCS, 1, "hit_pulse_count");
      tick(2);

      // Stale ok blanking: rom_ok held high, rom_cs high exactly 2 clk
      rom_ok = 1'b1; rom_data = 16'h1234;
      bank = 4'h0; addr = 20'h00010; roe_n = 1'b0;
      expect_at(1, K_CS, 1, "stale_cs_issue");
      expect_at(2, K_CS, 1, "stale_cs_wait");
      expect_at(2, K_DATA, 32'hEF, "stale_no_fill_in_issue");
      expect_at(3, K_CS, 0, "stale_cs_fall");
      expect_at(3, K_DATA, 32'h34, "stale_fill");
      tick(1);
      roe_n = 1'b1;
      tick(2);
      rom_ok = 1'b0;
      tick(1);

      // Overrun: second request lands in WAIT together with a rom_ok
      addr = 20'h00100; roe_n = 1'b0;
      tick(1);
      roe_n = 1'b1;
      tick(1);
      addr = 20'h00400; roe_n = 1'b0; rom_ok = 1'b1; rom_data = 16'hAAAA;
      expect_at(1, K_OVR, 1, "ovr_set");
      expect_at(1, K_ADDR, 32'h000200, "ovr_romaddr");
      expect_at(1, K_CS, 1, "ovr_cs_kept");
      expect_at(1, K_DATA, 32'h34, "ovr_superseded_no_data");
      tick(1);
      roe_n = 1'b1; rom_data = 16'h5566;
      expect_at(1, K_DATA, 32'h34, "ovr_issue_blank");
      expect_at(2, K_DATA, 32'h66, "ovr_second_byte");
      expect_at(2, K_CS, 0, "ovr_cs_fall");
      expect_at(2, K_NCS, 3, "ovr_single_pulse");
      tick(2);
      rom_ok = 1'b0;
      tick(1);
      expect_at(0, K_OVR, 1, "ovr_sticky");
      clr_ovr = 1'b1;
      expect_at(1, K_OVR, 0, "ovr_cleared");
      tick(1);
      clr_ovr = 1'b0;
      tick(1);

      // Flush: hit first, then flush, same word must miss
      addr = 20'h00401; roe_n = 1'b0;
      expect_at(1, K_DATA, 32'h55, "flush_prehit");
      expect_at(1, K_CS, 0, "flush_prehit_no_cs");
      tick(1);
      roe_n = 1'b1; flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(1);
      addr = 20'h00400; roe_n = 1'b0;
      expect_at(1, K_CS, 1, "flush_miss_cs");
      expect_at(1, K_ADDR, 32'h000200, "flush_miss_addr");
      tick(1);
      roe_n = 1'b1; rom_ok = 1'b1; rom_data = 16'h7788;
      expect_at(2, K_DATA, 32'h88, "flush_refill");
      expect_at(2, K_NCS, 4, "flush_pulse_count");
      tick(2);
      rom_ok = 1'b0;
      tick(2);

      // Reset asserted mid-WAIT
      addr = 20'h00800; roe_n = 1'b0;
      tick(1);
      roe_n = 1'b1;
      tick(1);
      expect_at(0, K_CS, 1, "rstmid_in_wait");
      tick(1);
      rst = 1'b1;
      expect_at(0, K_CS, 0, "rstmid_cs_drop");
      expect_at(0, K_DATA, 0, "rstmid_datain");
      expect_at(0, K_ADDR, 0, "rstmid_romaddr");
      tick(1);
      rst = 1'b0; rom_ok = 1'b1; rom_data = 16'h9999;
      tick(2);
      expect_at(0, K_CS, 0, "rstmid_late_ok_cs");
      expect_at(0, K_DATA, 0, "rstmid_late_ok_data");
      rom_ok = 1'b0;
      tick(1);
      // Cache must be invalid: a request to the old word misses
      addr = 20'h00400; roe_n = 1'b0;
      expect_at(1, K_CS, 1, "rstmid_cache_invalid");
      expect_at(1, K_DATA, 0, "rstmid_no_hit_data");
      tick(1);
      roe_n = 1'b1;
      tick(3);

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
      $finish;
   end

endmodule
